psram_arbiter: RTL and testbench
================================

# psram_arbiter

Two-port arbiter sharing the single HyperRAM/PSRAM command interface of the TangNano9K Atom build between the 6502 bus interface (CPU port) and a secondary byte master (DMA port: ROM loader / SD transfer engine). It holds one transaction in flight and registers all memory-side outputs. It returns read data and a completion pulse to the granted port. The CPU has priority, bounded by a DMA anti-starvation limit, and a watchdog covers lost completions.

## Interface
Parameters:
- ADDR_W, 22, byte address width on all ports
- STARVE_LIMIT, 4, consecutive CPU grants with DMA pending before DMA is forced (1..15)
- TIMEOUT, 255, cycles allowed in WAIT before forced completion (1..255)

Ports:
- clock  in  1  single system clock
- reset_n  in  1  reset, asynchronous, active-low
- cpu_req  in  1  level request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  8  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data, valid while cpu_ack is high
- dma_req / dma_we / dma_addr / dma_wdata / dma_ack / dma_rdata  same widths and meanings as the cpu_* ports
- mem_valid  out  1  command valid
- mem_ready  in  1  controller accepts command
- mem_we / mem_addr / mem_wdata  out  1 / ADDR_W / 8  command fields
- mem_rvalid  in  1  completion pulse for reads and writes
- mem_rdata  in  8  read data, qualified by mem_rvalid
- timeout_err  out  1  one-cycle pulse, coincident with the ack of a timed-out access
- busy  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: drive the command.
  - WAIT: await mem_rvalid.
  - DONE: pulse ack.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise latch the winner's we/addr/wdata and the grant id, then go to ISSUE.
- Arbitration:
  - CPU wins if cpu_req is high, unless dma_req is high and skip_cnt equals STARVE_LIMIT; in that case DMA wins.
  - DMA wins if only dma_req is high.
- skip_cnt (4 bits):
  - Increments when the CPU is granted while dma_req is high.
  - Clears on every DMA grant.
  - Saturates at STARVE_LIMIT.
  - Unchanged when the CPU is granted with dma_req low.
- ISSUE:
  - mem_valid = 1, fields driven from the latch.
  - On mem_valid & mem_ready, go to WAIT and clear wd_cnt.
  - With no ready, wait indefinitely; fields stay stable.
- WAIT:
  - wd_cnt increments each cycle.
  - On mem_rvalid, capture mem_rdata and go to DONE.
  - When wd_cnt reaches TIMEOUT first, load data 0xFF, set the err flag, and go to DONE.
- DONE:
  - Granted port's ack = 1; its rdata = captured byte (also driven for writes, don't-care there).
  - timeout_err = err flag.
  - Next state IDLE.
- mem_rvalid outside WAIT is ignored; a late completion after a timeout is dropped.
- Non-granted port: ack = 0, rdata = 0.
- Requester rule: deassert req (or change fields) in the cycle after ack is seen. The arbiter never samples a request in DONE, so no duplicate grant occurs.
- Reset values: state IDLE, skip_cnt 0, wd_cnt 0, every output 0 (mem_valid, acks, rdata, mem_* fields, timeout_err, busy).
- Reset mid-transaction aborts immediately and nothing is acked. Any controller completion arriving afterwards in IDLE is ignored.

## Timing
- Request high at cycle 0 (IDLE) → mem_valid at cycle 1.
- With mem_ready at 1: WAIT at cycle 2. Earliest mem_rvalid at cycle 2 → ack at cycle 3.
- Minimum request-to-ack latency is 3 cycles; a new grant is possible at cycle 4.
- Per-access cycles: 3 + (ISSUE stall cycles) + (WAIT cycles before rvalid).
- Timeout: ack occurs TIMEOUT + 1 cycles after entry to WAIT, when no rvalid arrives.
- Simultaneous requests in IDLE are resolved in that single cycle; the loser's request stays pending.
- All outputs are registered; no combinational input→output path.

## Structure
- Package psram_arb_pkg holds:
  - state enum: IDLE, ISSUE, WAIT, DONE
  - grant ids: GNT_CPU = 0, GNT_DMA = 1
  - default read data on timeout: 8'hFF
- Single module with no sub-module; the two counters and the FSM are small enough to keep inline (~200 lines).

## Test plan
- CPU read at addr 0x20010, mem_ready=1, mem_rvalid 4 cycles after accept with 0x5A → mem_addr=0x20010, mem_we=0, cpu_ack exactly once with cpu_rdata=0x5A, dma_ack never.
- Both requesting continuously, STARVE_LIMIT=4 → grant sequence CPU,CPU,CPU,CPU,DMA repeating; skip_cnt returns to 0 after each DMA grant.
- DMA write 0x3C to 0x00100 with mem_ready held low 10 cycles → mem_valid held 11 cycles with stable fields, dma_ack 1 cycle after rvalid.
- No mem_rvalid, TIMEOUT=8 → cpu_ack with cpu_rdata=0xFF and timeout_err=1 at WAIT entry + 9; a late mem_rvalid 5 cycles later causes no ack.
- reset_n asserted while in WAIT → all outputs 0 immediately; the subsequent stray mem_rvalid causes no ack. After release, a CPU read completes normally with 3-cycle minimum latency.

Source files
------------

// File: rtl/psram_arb_pkg.sv
// Shared types and constants for the PSRAM command-port arbiter.
package psram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DMA = 1'b1;

  localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

  // Saturating 4-bit increment used by the starvation counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] val, input logic [3:0] lim);
    if (val >= lim) begin
      sat_inc4 = lim;
    end else begin
      sat_inc4 = val + 4'd1;
    end
  endfunction

endpackage

// File: rtl/psram_arbiter.sv
// Two-port (CPU priority, DMA anti-starvation) arbiter for the single PSRAM
// command interface; one transaction in flight, all outputs registered.
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int ADDR_W       = 22,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_ack,
  output logic [7:0]        dma_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  output logic              timeout_err,
  output logic              busy
);

  localparam logic [3:0] STARVE_W  = 4'(STARVE_LIMIT);
  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  state_t      state_r;
  logic        gnt_r;
  logic [3:0]  skip_cnt_r;
  logic [7:0]  wd_cnt_r;

  logic        cpu_win_s;
  logic        wait_done_s;
  logic        done_err_s;
  logic [7:0]  done_data_s;

  // Arbitration winner and WAIT-state completion (rvalid beats a same-cycle timeout).
  always_comb begin
    cpu_win_s   = 1'b0;
    wait_done_s = 1'b0;
    done_err_s  = 1'b0;
    done_data_s = 8'h00;
    if (cpu_req && !(dma_req && (skip_cnt_r == STARVE_W))) begin
      cpu_win_s = 1'b1;
    end else begin
      cpu_win_s = 1'b0;
    end
    if (mem_rvalid) begin
      wait_done_s = 1'b1;
      done_data_s = mem_rdata;
    end else if (wd_cnt_r == TIMEOUT_W) begin
      wait_done_s = 1'b1;
      done_err_s  = 1'b1;
      done_data_s = TIMEOUT_RDATA;
    end else begin
      wait_done_s = 1'b0;
    end
  end

  // Transaction FSM with registered command, ack and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      gnt_r       <= GNT_CPU;
      skip_cnt_r  <= 4'd0;
      wd_cnt_r    <= 8'd0;
      mem_valid   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 8'h00;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= 8'h00;
      dma_ack     <= 1'b0;
      dma_rdata   <= 8'h00;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cpu_req || dma_req) begin
            if (cpu_win_s) begin
              gnt_r     <= GNT_CPU;
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              if (dma_req) begin
                skip_cnt_r <= sat_inc4(skip_cnt_r, STARVE_W);
              end
            end else begin
              gnt_r      <= GNT_DMA;
              mem_we     <= dma_we;
              mem_addr   <= dma_addr;
              mem_wdata  <= dma_wdata;
              skip_cnt_r <= 4'd0;
            end
            mem_valid <= 1'b1;
            busy      <= 1'b1;
            state_r   <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_valid && mem_ready) begin
            mem_valid <= 1'b0;
            wd_cnt_r  <= 8'd0;
            state_r   <= WAIT;
          end
        end
        WAIT: begin
          if (wait_done_s) begin
            timeout_err <= done_err_s;
            state_r     <= DONE;
            if (gnt_r == GNT_CPU) begin
              cpu_ack   <= 1'b1;
              cpu_rdata <= done_data_s;
            end else begin
              dma_ack   <= 1'b1;
              dma_rdata <= done_data_s;
            end
          end else begin
            wd_cnt_r <= wd_cnt_r + 8'd1;
          end
        end
        DONE: begin
          cpu_ack     <= 1'b0;
          cpu_rdata   <= 8'h00;
          dma_ack     <= 1'b0;
          dma_rdata   <= 8'h00;
          timeout_err <= 1'b0;
          busy        <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          mem_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Randomized self-checking bench for psram_arbiter against a transaction-level model.
module tb_psram_arbiter;

  localparam int ADDR_W       = 22;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 8;

  logic              clock;
  logic              reset_n;
  logic              cpu_req, cpu_we, cpu_ack;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata, cpu_rdata;
  logic              dma_req, dma_we, dma_ack;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_wdata, dma_rdata;
  logic              mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;
  logic              timeout_err, busy;

  psram_arbiter #(
    .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pending request per port (0 = CPU, 1 = DMA), starvation count, memory contents.
  logic              p_req  [2];
  logic              p_we   [2];
  logic [ADDR_W-1:0] p_addr [2];
  logic [7:0]        p_wd   [2];
  int                cpu_wins_while_dma_waits;
  logic [7:0]        mem_m [logic [ADDR_W-1:0]];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_pins();
    cpu_req = p_req[0]; cpu_we = p_we[0]; cpu_addr = p_addr[0]; cpu_wdata = p_wd[0];
    dma_req = p_req[1]; dma_we = p_we[1]; dma_addr = p_addr[1]; dma_wdata = p_wd[1];
  endtask

  task automatic new_req(input int p, input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    p_req[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wd[p] = d;
    apply_pins();
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
    check_val({tag, "_dma_ack"}, 32'(dma_ack), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    check_val({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_val({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_val({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check_val({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
    check_val({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    check_val({tag, "_dma_ack"}, 32'(dma_ack), 32'd0);
    check_val({tag, "_dma_rdata"}, 32'(dma_rdata), 32'd0);
    check_val({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Starts in an IDLE cycle with requests on the pins; ends in the ack cycle.
  // k = cycles after WAIT entry before rvalid; k > TIMEOUT means no rvalid at all.
  task automatic run_txn(input int stall, input int k, output int winner);
    int w;
    int lat;
    bit to;
    bit done;
    logic [7:0] data;
    logic [7:0] rd_exp;
    if (p_req[0] && !(p_req[1] && cpu_wins_while_dma_waits >= STARVE_LIMIT)) w = 0;
    else w = 1;
    if (w == 1) cpu_wins_while_dma_waits = 0;
    else if (p_req[1]) cpu_wins_while_dma_waits++;
    to = (k > TIMEOUT);
    if (p_we[w]) begin
      mem_m[p_addr[w]] = p_wd[w];
      data = 8'($urandom);
    end else begin
      if (!mem_m.exists(p_addr[w])) mem_m[p_addr[w]] = 8'($urandom);
      data = mem_m[p_addr[w]];
    end
    rd_exp = to ? 8'hFF : data;

    tick(); lat = 1;
    check_val("cmd_valid", 32'(mem_valid), 32'd1);
    check_val("cmd_busy", 32'(busy), 32'd1);
    check_val("cmd_addr", 32'(mem_addr), 32'(p_addr[w]));
    check_val("cmd_we", 32'(mem_we), 32'(p_we[w]));
    check_val("cmd_wdata", 32'(mem_wdata), 32'(p_wd[w]));
    for (int i = 0; i < stall; i++) begin
      mem_ready = 1'b0;
      tick(); lat++;
      check_val("stall_valid", 32'(mem_valid), 32'd1);
      check_val("stall_addr", 32'(mem_addr), 32'(p_addr[w]));
      check_val("stall_wdata", 32'(mem_wdata), 32'(p_wd[w]));
    end
    mem_ready = 1'b1;
    tick(); lat++;
    mem_ready = 1'b0;
    check_val("wait_valid_low", 32'(mem_valid), 32'd0);

    for (int c = 0; c <= TIMEOUT + 1; c++) begin
      if (c == k) begin
        mem_rvalid = 1'b1;
        mem_rdata  = data;
      end
      tick(); lat++;
      mem_rvalid = 1'b0;
      mem_rdata  = 8'($urandom);
      done = to ? (c == TIMEOUT) : (c == k);
      check_val("cpu_ack", 32'(cpu_ack), 32'(done && w == 0));
      check_val("dma_ack", 32'(dma_ack), 32'(done && w == 1));
      if (done) begin
        check_val("rdata_win", 32'(w == 0 ? cpu_rdata : dma_rdata), 32'(rd_exp));
        check_val("rdata_lose", 32'(w == 0 ? dma_rdata : cpu_rdata), 32'd0);
        check_val("timeout_err", 32'(timeout_err), 32'(to));
        check_val("latency", 32'(lat), 32'(to ? 3 + stall + TIMEOUT : 3 + stall + k));
        break;
      end
    end
    p_req[w] = 1'b0;
    apply_pins();
    winner = w;
  endtask

  int w;
  int nsel;

  initial begin
    reset_n = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 8'h00;
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wd[p] = 8'h00;
    end
    apply_pins();
    cpu_wins_while_dma_waits = 0;
    tick(); tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // CPU read at 0x20010, rvalid 4 cycles after accept.
    mem_m[22'h20010] = 8'h5A;
    new_req(0, 1'b0, 22'h20010, 8'h00);
    run_txn(0, 4, w);
    check_val("t1_winner", 32'(w), 32'd0);
    tick(); check_quiet("t1_idle");

    // Both requesting continuously: CPU x4 then DMA.
    for (int i = 0; i < 10; i++) begin
      for (int p = 0; p < 2; p++)
        if (!p_req[p]) new_req(p, 1'($urandom), 22'h20000 + 22'($urandom_range(0, 15)), 8'($urandom));
      run_txn($urandom_range(0, 2), $urandom_range(0, 3), w);
      check_val("starve_seq", 32'(w), 32'((i % 5 == 4) ? 1 : 0));
      tick(); check_val("starve_idle_ack", 32'(cpu_ack | dma_ack), 32'd0);
    end

    // Random traffic; pending losers carry over.
    for (int i = 0; i < 80 || p_req[0] || p_req[1]; i++) begin
      if (i < 80) begin
        for (int p = 0; p < 2; p++)
          if (!p_req[p] && $urandom_range(0, 1) == 1)
            new_req(p, 1'($urandom), 22'h20000 + 22'($urandom_range(0, 15)), 8'($urandom));
        if (!p_req[0] && !p_req[1]) begin
          nsel = $urandom_range(0, 1);
          new_req(nsel, 1'($urandom), 22'h20000 + 22'($urandom_range(0, 15)), 8'($urandom));
        end
      end
      run_txn($urandom_range(0, 3),
              ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : $urandom_range(0, 5), w);
      tick();
      check_val("rand_idle_ack", 32'(cpu_ack | dma_ack), 32'd0);
      check_val("rand_idle_valid", 32'(mem_valid), 32'd0);
    end
    tick(); check_quiet("drained");

    // DMA write with 10 stall cycles.
    new_req(1, 1'b1, 22'h00100, 8'h3C);
    run_txn(10, 2, w);
    check_val("t3_winner", 32'(w), 32'd1);
    tick(); check_quiet("t3_idle");

    // Timeout, then a late completion that must be dropped.
    new_req(0, 1'b0, 22'h20004, 8'h00);
    run_txn(0, TIMEOUT + 1, w);
    for (int i = 0; i < 4; i++) tick();
    mem_rvalid = 1'b1; mem_rdata = 8'h77;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_quiet("late_rvalid");
      tick();
    end

    // Reset while in WAIT.
    new_req(0, 1'b0, 22'h20008, 8'h00);
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    check_val("pre_reset_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    p_req[0] = 1'b0;
    apply_pins();
    cpu_wins_while_dma_waits = 0;
    #1;
    check_all_zero("mid_reset");
    tick();
    reset_n = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 8'h99;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_quiet("stray_rvalid");
      tick();
    end
    mem_m[22'h20030] = 8'hC3;
    new_req(0, 1'b0, 22'h20030, 8'h00);
    run_txn(0, 0, w);
    check_val("post_reset_winner", 32'(w), 32'd0);
    tick(); check_quiet("final_idle");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
